// File: rtl/pc_fetch_unit.sv
// PC + fetch stage: holds the PC, fetches over req/ready, hands instructions to decode over valid/accept.
// Optional PC_FETCH_BRANCH_STATS_EN adds taken_count/fetch_count counters.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_accept,
  input  logic              branch_taken,
  input  logic              jal,
  input  logic              jalr,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] jalr_addr,
  input  logic              halt,
`ifdef PC_FETCH_BRANCH_STATS_EN
  output logic [31:0]       taken_count,
  output logic [31:0]       fetch_count,
`endif
  output logic              misalign_err,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_instr;
  logic              r_req;
  logic              r_valid;
  logic              r_misalign;
  logic              r_halted;
`ifdef PC_FETCH_BRANCH_STATS_EN
  logic [31:0]       r_taken_count;
  logic [31:0]       r_fetch_count;
`endif

  logic              w_redirect;
  logic [ADDR_W-1:0] w_jalr_tgt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_misaligned;

  // JALR wins over JAL/branch; JALR bit 0 is dropped before the alignment check.
  assign w_redirect   = jalr | jal | branch_taken;
  assign w_jalr_tgt   = jalr_addr & ~{{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_pc_inc     = r_pc + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign w_next_pc    = jalr ? w_jalr_tgt : ((jal | branch_taken) ? target_addr : w_pc_inc);
  assign w_misaligned = jalr ? w_jalr_tgt[1] : (target_addr[1] | target_addr[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_pc_out   <= RESET_PC;
      r_instr    <= NOP;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_halted   <= 1'b0;
`ifdef PC_FETCH_BRANCH_STATS_EN
      r_taken_count <= '0;
      r_fetch_count <= '0;
`endif
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (halt) begin
            r_req    <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else if (imem_ready) begin
            r_instr  <= imem_rdata;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_req    <= 1'b0;
            r_state  <= S_VALID;
`ifdef PC_FETCH_BRANCH_STATS_EN
            r_fetch_count <= r_fetch_count + 32'd1;
`endif
          end
        end
        S_VALID: begin
          // Halt retires (or drops) the held instruction without touching the PC.
          if (halt) begin
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else if (instr_accept) begin
            r_valid <= 1'b0;
            if (w_redirect && w_misaligned) begin
              r_misalign <= 1'b1;
              r_halted   <= 1'b1;
              r_state    <= S_HALTED;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= S_REQ;
`ifdef PC_FETCH_BRANCH_STATS_EN
              if (w_redirect) r_taken_count <= r_taken_count + 32'd1;
`endif
            end
          end
        end
        S_HALTED: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_pc;
  assign instr_out    = r_instr;
  assign pc_out       = r_pc_out;
  assign instr_valid  = r_valid;
  assign misalign_err = r_misalign;
  assign halted       = r_halted;
`ifdef PC_FETCH_BRANCH_STATS_EN
  assign taken_count  = r_taken_count;
  assign fetch_count  = r_fetch_count;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: scoreboard of expected fetch addresses, filled on each accept.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic [31:0] target_addr;
  logic [31:0] jalr_addr;
  logic        halt;
  logic        misalign_err;
  logic        halted;
`ifdef PC_FETCH_BRANCH_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] fetch_count;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  int          exp_taken = 0;
  int          exp_fetch = 0;

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid), .instr_accept(instr_accept),
    .branch_taken(branch_taken), .jal(jal), .jalr(jalr), .target_addr(target_addr),
    .jalr_addr(jalr_addr), .halt(halt),
`ifdef PC_FETCH_BRANCH_STATS_EN
    .taken_count(taken_count), .fetch_count(fetch_count),
`endif
    .misalign_err(misalign_err), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  task automatic idle_inputs();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF; instr_accept = 1'b0;
    branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0; target_addr = '0; jalr_addr = '0; halt = 1'b0;
  endtask

  // Bounded wait (at negedges) for imem_req.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) exp_addr = 32'hFFFF_FFFF;
    else exp_addr = exp_q.pop_front();
  endtask

  // One-cycle memory response for the address currently requested.
  task automatic serve();
    imem_ready = 1'b1; imem_rdata = instr_of(imem_addr);
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    exp_fetch++;
  endtask

  // Accept the held instruction; the reference next-PC goes to the scoreboard.
  task automatic do_accept(input logic bt, input logic j, input logic jr,
                           input logic [31:0] tgt, input logic [31:0] jaddr, input logic hlt);
    logic [31:0] nxt;
    logic        mis;
    if (jr) begin
      nxt = {jaddr[31:1], 1'b0}; mis = nxt[1];
    end else if (j || bt) begin
      nxt = tgt; mis = (tgt[1:0] != 2'b00);
    end else begin
      nxt = exp_addr + 32'd4; mis = 1'b0;
    end
    if (!hlt && !mis) begin
      exp_q.push_back(nxt);
      if (bt || j || jr) exp_taken++;
    end
    instr_accept = 1'b1; branch_taken = bt; jal = j; jalr = jr;
    target_addr = tgt; jalr_addr = jaddr; halt = hlt;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl req=%b valid=%b mis=%b halted=%b required 0 0 0 0",
               imem_req, instr_valid, misalign_err, halted);
    end
    checks++;
    if (instr_out !== 32'h0000_0013 || pc_out !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_data instr=%h pc_out=%h addr=%h required 00000013 0 0",
               instr_out, pc_out, imem_addr);
    end
`ifdef PC_FETCH_BRANCH_STATS_EN
    checks++;
    if (taken_count !== 32'd0 || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts taken=%0d fetch=%0d required 0 0", taken_count, fetch_count);
    end
`endif
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_taken = 0; exp_fetch = 0;
  endtask

  typedef struct {
    logic        bt;
    logic        j;
    logic        jr;
    logic [31:0] tgt;
    logic [31:0] jaddr;
  } step_t;

  task automatic test_sequence_and_redirects();
    step_t steps[6];
    bit    ok;
    steps[0] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
    steps[1] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
    steps[2] = '{1'b0, 1'b0, 1'b0, 32'h44, 32'h0};    // not taken at 0x8 -> 0xC
    steps[3] = '{1'b1, 1'b0, 1'b0, 32'h8,  32'h0};    // back to 0x8
    steps[4] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0};    // taken at 0x8 -> 0x40
    steps[5] = '{1'b0, 1'b1, 1'b1, 32'h80, 32'h101};  // jal+jalr -> 0x100
    for (int i = 0; i < 6; i++) begin
      wait_req(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL seq_req_timeout step=%0d imem_req=%b required 1", i, imem_req); end
      pop_exp();
      checks++;
      if (imem_addr !== exp_addr || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_addr step=%0d addr=%h valid=%b required %h 0", i, imem_addr, instr_valid, exp_addr);
      end
      serve();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== exp_addr || instr_out !== instr_of(exp_addr) || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL seq_valid step=%0d valid=%b pc_out=%h instr=%h req=%b required 1 %h %h 0",
                 i, instr_valid, pc_out, instr_out, imem_req, exp_addr, instr_of(exp_addr));
      end
      do_accept(steps[i].bt, steps[i].j, steps[i].jr, steps[i].tgt, steps[i].jaddr, 1'b0);
    end
    // At 0x100: resolution inputs without accept must be ignored.
    wait_req(ok);
    pop_exp();
    checks++;
    if (!ok || imem_addr !== exp_addr || exp_addr !== 32'h100) begin
      failures++;
      $display("FAIL jalr_prio_addr addr=%h required 00000100", imem_addr);
    end
    serve();
    branch_taken = 1'b1; jal = 1'b1; target_addr = 32'h200;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h100 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL no_accept_ignored valid=%b pc_out=%h req=%b addr=%h required 1 100 0 100",
               instr_valid, pc_out, imem_req, imem_addr);
    end
    do_accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_delayed_ready();
    bit ok;
    wait_req(ok);
    pop_exp();
    checks++;
    if (!ok || imem_addr !== exp_addr || exp_addr !== 32'h104) begin
      failures++;
      $display("FAIL delay_first_addr addr=%h required 00000104", imem_addr);
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL delay_stable wait=%0d req=%b addr=%h valid=%b required 1 %h 0",
                 d, imem_req, imem_addr, instr_valid, exp_addr);
      end
    end
    serve();
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== exp_addr || instr_out !== instr_of(exp_addr)) begin
      failures++;
      $display("FAIL delay_capture valid=%b pc_out=%h instr=%h required 1 %h %h",
               instr_valid, pc_out, instr_out, exp_addr, instr_of(exp_addr));
    end
    do_accept(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
  endtask

  task automatic test_halt();
    bit ok;
    wait_req(ok);
    pop_exp();
    checks++;
    if (!ok || imem_addr !== exp_addr || exp_addr !== 32'h10) begin
      failures++;
      $display("FAIL halt_pre_addr addr=%h required 00000010", imem_addr);
    end
    serve();
    do_accept(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin imem_ready = 1'b1; imem_rdata = 32'h1234_5678; end
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
        failures++;
        $display("FAIL halt_state cyc=%0d halted=%b req=%b valid=%b mis=%b required 1 0 0 0",
                 c, halted, imem_req, instr_valid, misalign_err);
      end
      @(negedge clk);
      imem_ready = 1'b0;
    end
    checks++;
    if (pc_out !== 32'h10 || imem_addr !== 32'h10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL halt_pc pc_out=%h addr=%h required 10 10", pc_out, imem_addr);
    end
`ifdef PC_FETCH_BRANCH_STATS_EN
    checks++;
    if (taken_count !== 32'(exp_taken) || fetch_count !== 32'(exp_fetch)) begin
      failures++;
      $display("FAIL halt_counts taken=%0d fetch=%0d required %0d %0d", taken_count, fetch_count, exp_taken, exp_fetch);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    bit ok;
    wait_req(ok);
    pop_exp();
    serve();
    do_accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    wait_req(ok);
    pop_exp();
    checks++;
    if (!ok || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL midrst_pre_addr addr=%h required 00000004", imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_taken = 0; exp_fetch = 0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 32'h0) begin
      failures++;
      $display("FAIL midrst_idle req=%b valid=%b pc_out=%h required 0 0 0", imem_req, instr_valid, pc_out);
    end
    @(negedge clk);
    pop_exp();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      failures++;
      $display("FAIL midrst_refetch req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_addr);
    end
  endtask

  task automatic test_misalign();
    serve();
    do_accept(1'b1, 1'b0, 1'b0, 32'h22, 32'h0, 1'b0);
    checks++;
    if (misalign_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse mis=%b halted=%b req=%b pc_out=%h valid=%b required 1 1 0 0 0",
               misalign_err, halted, imem_req, pc_out, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0 || halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL misalign_after mis=%b halted=%b req=%b addr=%h required 0 1 0 0",
               misalign_err, halted, imem_req, imem_addr);
    end
`ifdef PC_FETCH_BRANCH_STATS_EN
    checks++;
    if (taken_count !== 32'(exp_taken) || fetch_count !== 32'(exp_fetch)) begin
      failures++;
      $display("FAIL misalign_counts taken=%0d fetch=%0d required %0d %0d", taken_count, fetch_count, exp_taken, exp_fetch);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    exp_addr = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_sequence_and_redirects();
    test_delayed_ready();
    test_halt();
    test_reset();
    test_reset_midflight();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
